// File: rtl/bram_dp_arbiter.sv
// bram_dp_arbiter
//   Round-robin arbiter that shares one true-dual-port, no-change BRAM between NUM_REQ
//   requesters. Up to two requests are granted per cycle: the first winner of the scan
//   drives port A and the second drives port B. A 2-stage tag pipe per port follows the
//   fixed 2-cycle BRAM read latency, so read data is steered back to the requester that
//   issued it.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_valid_i/req_we_i       per-requester valid and write flag
//   req_addr_i/req_wdata_i     flattened address / write data, requester i at slice i
//   req_ready_o                grant; a transfer happens when valid & ready
//   rsp_valid_o/rsp_rdata_o    read response pulse and data, per requester
//   bram_*_o                   BRAM port A/B enables, write enables, address, data in,
//                              output-register reset (active-low) and clock enable
//   bram_douta_i/bram_doutb_i  BRAM registered read data
`timescale 1ns / 1ps

module bram_dp_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned ADDR_LINES = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*ADDR_LINES-1:0]    req_addr_i,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic [NUM_REQ*RAM_WIDTH-1:0]     rsp_rdata_o,
  output logic                             bram_ena_o,
  output logic                             bram_enb_o,
  output logic                             bram_wea_o,
  output logic                             bram_web_o,
  output logic [ADDR_LINES-1:0]            bram_addra_o,
  output logic [ADDR_LINES-1:0]            bram_addrb_o,
  output logic [RAM_WIDTH-1:0]             bram_dina_o,
  output logic [RAM_WIDTH-1:0]             bram_dinb_o,
  output logic                             bram_rstna_o,
  output logic                             bram_rstnb_o,
  output logic                             bram_regcea_o,
  output logic                             bram_regceb_o,
  input  logic [RAM_WIDTH-1:0]             bram_douta_i,
  input  logic [RAM_WIDTH-1:0]             bram_doutb_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IdxW-1:0] idx_t;

  // Per-requester views of the flattened buses
  logic [ADDR_LINES-1:0] addr  [NUM_REQ];
  logic [RAM_WIDTH-1:0]  wdata [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr[i]  = req_addr_i[i*ADDR_LINES +: ADDR_LINES];
    assign wdata[i] = req_wdata_i[i*RAM_WIDTH +: RAM_WIDTH];
  end

  idx_t rr_ptr_q, rr_ptr_d;
  logic a_found, b_found;
  idx_t a_idx, b_idx;
  logic collide, b_grant;
  idx_t last_idx;

  // Read tag pipes: stage 0 is captured at the grant edge, stage 1 lines up with BRAM dout
  logic [1:0] tag_a_vld_q, tag_b_vld_q;
  idx_t       tag_a_idx0_q, tag_a_idx1_q;
  idx_t       tag_b_idx0_q, tag_b_idx1_q;

  // Scan starting at rr_ptr with explicit modulo wrap so non-power-of-two counts work.
  always_comb begin : p_arb
    int unsigned cand;
    idx_t        cand_idx;
    cand     = 0;
    cand_idx = '0;
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = idx_t'(cand);
      if (req_valid_i[cand_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = cand_idx;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = cand_idx;
        end
      end
    end
  end

  // Same-address pair involving a write would be undefined across ports; B waits a cycle.
  assign collide = a_found && b_found && (addr[a_idx] == addr[b_idx]) &&
                   (req_we_i[a_idx] || req_we_i[b_idx]);
  assign b_grant = b_found && !collide;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    last_idx = b_grant ? b_idx : a_idx;
    if (a_found) begin
      rr_ptr_d = (last_idx == idx_t'(NUM_REQ - 1)) ? '0 : last_idx + idx_t'(1);
    end
  end

  always_comb begin
    req_ready_o  = '0;
    bram_ena_o   = 1'b0;
    bram_wea_o   = 1'b0;
    bram_addra_o = '0;
    bram_dina_o  = '0;
    bram_enb_o   = 1'b0;
    bram_web_o   = 1'b0;
    bram_addrb_o = '0;
    bram_dinb_o  = '0;
    if (!rst_i) begin
      if (a_found) begin
        req_ready_o[a_idx] = 1'b1;
        bram_ena_o         = 1'b1;
        bram_wea_o         = req_we_i[a_idx];
        bram_addra_o       = addr[a_idx];
        bram_dina_o        = wdata[a_idx];
      end
      if (b_grant) begin
        req_ready_o[b_idx] = 1'b1;
        bram_enb_o         = 1'b1;
        bram_web_o         = req_we_i[b_idx];
        bram_addrb_o       = addr[b_idx];
        bram_dinb_o        = wdata[b_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      tag_a_vld_q  <= '0;
      tag_b_vld_q  <= '0;
      tag_a_idx0_q <= '0;
      tag_a_idx1_q <= '0;
      tag_b_idx0_q <= '0;
      tag_b_idx1_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      tag_a_vld_q  <= {tag_a_vld_q[0], a_found & ~req_we_i[a_idx]};
      tag_b_vld_q  <= {tag_b_vld_q[0], b_grant & ~req_we_i[b_idx]};
      tag_a_idx0_q <= a_idx;
      tag_a_idx1_q <= tag_a_idx0_q;
      tag_b_idx0_q <= b_idx;
      tag_b_idx1_q <= tag_b_idx0_q;
    end
  end

  // A requester owns at most one port per grant cycle, so hit_a and hit_b never coincide.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    logic hit_a, hit_b;
    assign hit_a          = tag_a_vld_q[1] && (tag_a_idx1_q == idx_t'(i));
    assign hit_b          = tag_b_vld_q[1] && (tag_b_idx1_q == idx_t'(i));
    assign rsp_valid_o[i] = ~rst_i & (hit_a | hit_b);
    assign rsp_rdata_o[i*RAM_WIDTH +: RAM_WIDTH] = hit_a ? bram_douta_i : bram_doutb_i;
  end

  assign bram_rstna_o  = ~rst_i;
  assign bram_rstnb_o  = ~rst_i;
  assign bram_regcea_o = 1'b1;
  assign bram_regceb_o = 1'b1;

endmodule
